// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - state codes, message constants and frame lookup for display_sequencer
package disp_pkg;

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_RASP     = 3'd1;
  localparam logic [2:0] ST_BAWP     = 3'd2;
  localparam logic [2:0] ST_P1_TURN  = 3'd3;
  localparam logic [2:0] ST_P2_TURN  = 3'd4;
  localparam logic [2:0] ST_MATCHRES = 3'd5;
  localparam logic [2:0] ST_GAMERES  = 3'd6;

  localparam logic [15:0] MSG_INIT  = 16'h1A1F;
  localparam logic [15:0] MSG_P1    = 16'h1FFF;
  localparam logic [15:0] MSG_P2    = 16'h2FFF;
  localparam logic [3:0]  BLANK_NIB = 4'hF;

  // Element 0 is the blank code.
  localparam logic [3:0][15:0] MATCH_MSG = {16'hADFF, 16'hA2FF, 16'hA1FF, 16'hFFFF};
  localparam logic [3:0][15:0] GAME_MSG  = {16'hCDFF, 16'hC2FF, 16'hC1FF, 16'hFFFF};

  function automatic logic [15:0] frame_of(
    input logic [2:0] st,
    input logic [3:0] round, win, lose,
    input logic [3:0] p1_black, p1_white, p2_black, p2_white,
    input logic [1:0] matchresult, gameresult
  );
    logic [15:0] f;
    case (st)
      ST_INIT:     f = MSG_INIT;
      ST_RASP:     f = {round, BLANK_NIB, win, lose};
      ST_BAWP:     f = {p1_black, p1_white, p2_black, p2_white};
      ST_P1_TURN:  f = MSG_P1;
      ST_P2_TURN:  f = MSG_P2;
      ST_MATCHRES: f = MATCH_MSG[matchresult];
      ST_GAMERES:  f = GAME_MSG[gameresult];
      default:     f = 16'hFFFF;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - digit-slot prescaler and scan index with synchronous clear
module scan_timer #(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 4,
  parameter int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  output logic          o_slot_tick,
  output logic          o_frame_wrap,
  output logic [IW-1:0] o_idx
);
  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic          w_last_digit;

  assign o_slot_tick  = (r_presc == PW'(SCAN_DIV - 1));
  assign w_last_digit = (r_idx == IW'(NUM_DIGITS - 1));
  assign o_frame_wrap = o_slot_tick && w_last_digit;
  assign o_idx        = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (i_clr) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (o_slot_tick) begin
      r_presc <= '0;
      r_idx   <= w_last_digit ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// rtl/display_sequencer.sv - tear-free frame latch, 7-segment scan and result-hold handshake
// Optional result-screen blinking: DISPLAY_SEQUENCER_BLINK_EN.
module display_sequencer
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int HOLD_FRAMES  = 200,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              state,
  input  logic [3:0]              round,
  input  logic [3:0]              win,
  input  logic [3:0]              lose,
  input  logic [3:0]              p1_black,
  input  logic [3:0]              p1_white,
  input  logic [3:0]              p2_black,
  input  logic [3:0]              p2_white,
  input  logic [1:0]              matchresult,
  input  logic [1:0]              gameresult,
  output logic [4*NUM_DIGITS-1:0] frame,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic [3:0]              digit_val,
  output logic                    msg_done
);
  localparam int FW = 4 * NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic            w_slot_tick, w_frame_wrap, w_state_chg, w_result, w_hidden;
  logic [IW-1:0]   w_idx;
  logic [15:0]     w_msg;
  logic [FW-1:0]   w_next_frame, w_frame_sh;
  logic [3:0]      w_nib;

  logic [FW-1:0]         r_frame;
  logic [NUM_DIGITS-1:0] r_digit_en_n;
  logic [3:0]            r_digit_val;
  logic                  r_msg_done, r_upd;
  logic [HW-1:0]         r_hold;
  logic [2:0]            r_prev_state;

  assign w_state_chg = (state != r_prev_state);
  assign w_result    = (state == ST_MATCHRES) || (state == ST_GAMERES);
  assign w_msg = frame_of(state, round, win, lose, p1_black, p1_white, p2_black, p2_white,
                          matchresult, gameresult);
  // Message occupies the leftmost digits; any extra digits are blank.
  assign w_next_frame = ({FW{1'b1}} >> 16) | (FW'(w_msg) << (FW - 16));
  assign w_frame_sh   = r_frame << {w_idx, 2'b00};
  assign w_nib        = w_frame_sh[FW-1 -: 4];

  scan_timer #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(NUM_DIGITS), .IW(IW)) u_scan_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_state_chg),
    .o_slot_tick  (w_slot_tick),
    .o_frame_wrap (w_frame_wrap),
    .o_idx        (w_idx)
  );

`ifdef DISPLAY_SEQUENCER_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] r_blink_cnt;
  logic          r_hidden;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_hidden    <= 1'b0;
    end else if (w_state_chg || !w_result) begin
      r_blink_cnt <= '0;
      r_hidden    <= 1'b0;
    end else if (w_frame_wrap) begin
      if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_hidden    <= ~r_hidden;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end
  assign w_hidden = r_hidden;
`else
  assign w_hidden = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame      <= {MSG_INIT, {(FW-16){1'b1}}};
      r_prev_state <= ST_INIT;
      r_hold       <= '0;
      r_msg_done   <= 1'b0;
    end else begin
      r_prev_state <= state;
      r_msg_done   <= 1'b0;
      if (w_state_chg) begin
        r_frame <= w_next_frame;
        r_hold  <= '0;
      end else begin
        if (w_frame_wrap) r_frame <= w_next_frame;
        if (!w_result) begin
          r_hold <= '0;
        end else if (w_frame_wrap && r_hold != HW'(HOLD_FRAMES)) begin
          r_hold     <= r_hold + 1'b1;
          r_msg_done <= (r_hold == HW'(HOLD_FRAMES - 1));
        end
      end
    end
  end

  // Index, frame and blink phase only move on a slot tick or state change,
  // so the digit registers need refreshing only on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd        <= 1'b0;
      r_digit_en_n <= ~NUM_DIGITS'(1);
      r_digit_val  <= MSG_INIT[15:12];
    end else begin
      r_upd <= w_slot_tick || w_state_chg;
      if (r_upd) begin
        r_digit_en_n <= ~(NUM_DIGITS'(1) << w_idx);
        r_digit_val  <= w_hidden ? BLANK_NIB : w_nib;
      end
    end
  end

  assign frame      = r_frame;
  assign digit_en_n = r_digit_en_n;
  assign digit_val  = r_digit_val;
  assign msg_done   = r_msg_done;

endmodule

// File: tb/tb_display_sequencer.sv
// tb/tb_display_sequencer.sv - scoreboard bench for display_sequencer
module tb_display_sequencer;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] v;
    string       nm;
  } exp_t;

`ifdef DISPLAY_SEQUENCER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  state = 3'd0;
  logic [3:0]  round = 4'd0, win = 4'd0, lose = 4'd0;
  logic [3:0]  p1_black = 4'd0, p1_white = 4'd0, p2_black = 4'd0, p2_white = 4'd0;
  logic [1:0]  matchresult = 2'd0, gameresult = 2'd0;
  logic [15:0] frame;
  logic [3:0]  digit_en_n;
  logic [3:0]  digit_val;
  logic        msg_done;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   pulse_q[$];

  display_sequencer #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .HOLD_FRAMES(3), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state),
    .round(round), .win(win), .lose(lose),
    .p1_black(p1_black), .p1_white(p1_white), .p2_black(p2_black), .p2_white(p2_white),
    .matchresult(matchresult), .gameresult(gameresult),
    .frame(frame), .digit_en_n(digit_en_n), .digit_val(digit_val), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic expect_at(input int c, input int s, input logic [15:0] v, input string n);
    exp_t e;
    e.cyc = c; e.sel = s; e.v = v; e.nm = n;
    q.push_back(e);
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: compares scheduled values and every msg_done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        logic [15:0] act;
        e = q.pop_front();
        case (e.sel)
          0:       act = frame;
          1:       act = {12'h000, digit_en_n};
          default: act = {12'h000, digit_val};
        endcase
        checks++;
        if (e.cyc != cyc || act !== e.v) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%h required=%h (due cyc %0d)", e.nm, cyc, act, e.v, e.cyc);
        end
      end
      if (msg_done) begin
        checks++;
        if (pulse_q.size() == 0) begin
          failures++;
          $display("FAIL msg_done_unexpected cyc=%0d actual=1 required=0", cyc);
        end else begin
          int p;
          p = pulse_q.pop_front();
          if (p != cyc) begin
            failures++;
            $display("FAIL msg_done_cycle actual=%0d required=%0d", cyc, p);
          end
        end
      end
    end
  end

  initial begin
    expect_at(0, 0, 16'h1A1F, "reset_frame");
    expect_at(0, 1, 16'hE, "reset_en");
    expect_at(0, 2, 16'h1, "reset_val");
    expect_at(4, 1, 16'hE, "scan_en_c4");
    expect_at(5, 1, 16'hD, "scan_en_c5");
    expect_at(5, 2, 16'hA, "scan_val_c5");
    expect_at(9, 1, 16'hB, "scan_en_c9");
    expect_at(9, 2, 16'h1, "scan_val_c9");
    expect_at(13, 1, 16'h7, "scan_en_c13");
    expect_at(13, 2, 16'hF, "scan_val_c13");
    expect_at(17, 1, 16'hE, "scan_en_c17");
    expect_at(21, 1, 16'hD, "scan_en_c21");
    expect_at(21, 2, 16'hA, "scan_val_c21");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    goto(24);
    state = 3'd1; round = 4'd3; win = 4'd2; lose = 4'd1;
    expect_at(25, 0, 16'h3F21, "rasp_frame");
    expect_at(26, 1, 16'hE, "rasp_restart_en");
    expect_at(26, 2, 16'h3, "rasp_restart_val");

    goto(30);
    win = 4'd5;
    expect_at(35, 0, 16'h3F21, "midframe_hold_a");
    expect_at(40, 0, 16'h3F21, "midframe_hold_b");
    expect_at(41, 0, 16'h3F51, "wrap_pickup");
    expect_at(50, 1, 16'hB, "rasp_en_d2");
    expect_at(50, 2, 16'h5, "rasp_val_d2");

    goto(60);
    state = 3'd5; matchresult = 2'd2;
    expect_at(61, 0, 16'hA2FF, "match_frame");
    expect_at(63, 1, 16'hE, "match_en_d0");
    expect_at(63, 2, 16'hA, "match_val_d0");
    expect_at(66, 2, 16'h2, "match_val_d1");
    expect_at(100, 2, BLINK ? 16'hF : 16'h2, "match_blink_phase");
    pulse_q.push_back(109);

    goto(140);
    state = 3'd6; gameresult = 2'd3;
    expect_at(141, 0, 16'hCDFF, "game_frame");
    expect_at(147, 2, 16'hD, "game_visible_a");
    expect_at(178, 2, BLINK ? 16'hF : 16'hD, "game_blink_phase");
    expect_at(210, 2, 16'hD, "game_visible_b");
    pulse_q.push_back(189);

    goto(220);
    state = 3'd5; matchresult = 2'd1;
    expect_at(221, 0, 16'hA1FF, "match1_frame");

    goto(250);
    state = 3'd0;
    expect_at(251, 0, 16'h1A1F, "exit_frame");

    goto(270);
    state = 3'd5;
    expect_at(271, 0, 16'hA1FF, "reentry_frame");
    pulse_q.push_back(319);

    goto(330);
    state = 3'd7;
    expect_at(331, 0, 16'hFFFF, "unused_frame");

    goto(345);
    state = 3'd2; p1_black = 4'd9; p1_white = 4'd8; p2_black = 4'd7; p2_white = 4'd6;
    expect_at(346, 0, 16'h9876, "bawp_frame");

    goto(350);
    state = 3'd4;
    expect_at(351, 0, 16'h2FFF, "p2_frame");

    goto(355);
    state = 3'd3;
    expect_at(356, 0, 16'h1FFF, "p1_frame");

    goto(365);
    @(posedge clk);
    checks++;
    if (q.size() != 0 || pulse_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations actual=%0d/%0d required=0/0", q.size(), pulse_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Parametrised successor of the game's combinational print selector; produces one frame of NUM_DIGITS BCD/hex nibbles per game state.
- Latches the frame tear-free and time-multiplexes it onto a common-digit 7-segment driver through a scan counter.
- Sits between the game FSM and the 7-segment decoder.
- Issues a msg_done handshake once result screens have been shown for a minimum time, so the FSM can advance.

Parameters:
- NUM_DIGITS, 4, digits per frame; frame width FW = 4*NUM_DIGITS.
- SCAN_DIV, 50000, clk cycles per digit slot; must be >= 2.
- HOLD_FRAMES, 200, full scan frames a result screen must be shown before msg_done.
- BLINK_FRAMES, 50, frames per blink half-period (BLINK_EN only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- state  in  3  game state code: 0 init, 1 rasp, 2 bawp, 3 p1_turn, 4 p2_turn, 5 matchresult, 6 gameresult, 7 unused
- round, win, lose  in  4 each  score fields
- p1_black, p1_white, p2_black, p2_white  in  4 each  card counts
- matchresult, gameresult  in  2 each  result codes
- frame  out  FW  latched frame; digit 0 = frame[FW-1:FW-4] (leftmost)
- digit_en_n  out  NUM_DIGITS  one-hot active-low digit enable
- digit_val  out  4  nibble for the enabled digit; 4'hF = blank
- msg_done  out  1  one-cycle pulse: result screen hold satisfied

Behaviour:
- Reset (async assert, sync release) values:
  - frame = MSG_INIT = 16'h1A1F
  - scan index = 0, prescaler = 0, digit_en_n = all ones except bit0 = 0
  - digit_val = 4'h1
  - msg_done = 0, hold count = 0, prev_state = 0
- Next-frame function (combinational):
  - 0: MSG_INIT
  - 1: {round, 4'hF, win, lose}
  - 2: {p1_black, p1_white, p2_black, p2_white}
  - 3: 16'h1FFF
  - 4: 16'h2FFF
  - 5: MATCH_MSG[matchresult]
  - 6: GAME_MSG[gameresult]
  - 7: all 4'hF
  - Nibbles are MSB-first; no bit reversal.
  - For NUM_DIGITS > 4, the 16-bit message sits in the leftmost digits and the rest are 4'hF.
- MATCH_MSG/GAME_MSG codes:
  - 0 = blank
  - 1 = {A,1,F,F} / {C,1,F,F}
  - 2 = {A,2,F,F} / {C,2,F,F}
  - 3 = {A,d,F,F} / {C,d,F,F}
- Frame load:
  - On state != prev_state: frame reloads on the next edge, and prescaler, scan index and hold count clear.
  - Otherwise frame reloads only on the edge where the scan index wraps NUM_DIGITS-1 -> 0. A frame never changes mid-scan.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count the scan index increments, wrapping at NUM_DIGITS-1.
  - digit_en_n and digit_val are registered and follow the index with 1-cycle latency.
- Hold/handshake:
  - In states 5 and 6, hold count increments per frame wrap and saturates at HOLD_FRAMES.
  - msg_done pulses exactly once, the cycle the count reaches HOLD_FRAMES; it does not re-pulse until a state change.
  - In other states, msg_done = 0 and hold count = 0.
- Simultaneous events: state change and frame wrap on the same cycle means the state change wins (counters clear, new frame loaded).
- Input fields changing within a state are picked up at the next frame wrap only.
- Reset mid-scan returns immediately to reset values.

Optional Feature:
- Macro: DISPLAY_SEQUENCER_BLINK_EN.
- Defined: in states 5 and 6, a blink phase toggles every BLINK_FRAMES frames, starting visible after each state change. While the phase is hidden, digit_val = 4'hF. frame and digit_en_n are unaffected.
- Undefined: no blink logic; digit_val always equals the frame nibble.

Decomposition:
- Package disp_pkg holds:
  - state code localparams (ST_INIT..ST_GAMERES)
  - MSG_INIT, MSG_P1, MSG_P2, BLANK_NIB
  - MATCH_MSG/GAME_MSG lookup constants
  - frame_of() function
- Sub-module scan_timer contains the prescaler and digit index; it outputs slot_tick and frame_wrap and takes a sync clear input.

Test Plan (SCAN_DIV=4, NUM_DIGITS=4, HOLD_FRAMES=3, BLINK_FRAMES=2):
- Reset with state=0:
  - Outputs are frame=16'h1A1F, digit_en_n=4'b1110, digit_val=1.
  - After 4 clks digit_en_n=4'b1101 and digit_val=4'hA; the pattern repeats every 16 clks.
- state=1, round=3, win=2, lose=1: next edge frame=16'h3F21 and scan restarts at digit 0.
- Mid-frame change of win from 2 to 5 (state held): frame stays 16'h3F21 until the wrap, then becomes 16'h3F51.
- state=5, matchresult=2: frame=16'hA2FF; msg_done pulses once exactly 48 clks after entry and stays 0 thereafter.
- Leaving state 5 at clk 30, then returning: no pulse on exit; the hold count restarts on re-entry.
- With BLINK_EN, state=6, gameresult=3: digit_val shows C,d,F,F for 2 frames, then F for 2 frames, alternating. Without BLINK_EN, no blanking occurs.
